// File: rtl/game_ram_arbiter.sv
// ---------------------------------------------------------------------------
// game_ram_arbiter
//
// Purpose:
//   Shares a single-port, four-row game RAM between three clients:
//   - a user edit port that read-modify-writes one digit of a row
//   - a checker read port
//   - a display read port
//   Edits always win. The two read ports take turns through a round-robin
//   pointer. Each transaction walks IDLE -> RD -> WAIT (-> WR for accepted
//   edits) and finishes with a single one-cycle ack, done or reject pulse.
//
// RAM word layout (24 bits):
//   [23:20] write-protect per digit, [19:16] blank per digit,
//   [15:0]  four 4-bit digits; digit c sits at [4c+3:4c].
//
// Ports:
//   CLK, RST_N             clock and synchronous active-low reset
//   RamAddr                row address, registered, held for the whole job
//   RamDat                 read data, valid the cycle after RamAddr
//   RamWrDat, RamWe        write word and one-cycle write strobe
//   edit_req/row/col/val/clr   edit request and its fields
//   edit_done, edit_rej    one-cycle completion / rejection pulses
//   chk_req/addr, chk_ack, chk_data     checker read port
//   disp_req/addr, disp_ack, disp_data  display read port
//   game_won               while high every edit is rejected
//   busy                   high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module game_ram_arbiter (
   input  logic        CLK,
   input  logic        RST_N,
   output logic [1:0]  RamAddr,
   input  logic [23:0] RamDat,
   output logic [23:0] RamWrDat,
   output logic        RamWe,
   input  logic        edit_req,
   input  logic [1:0]  edit_row,
   input  logic [1:0]  edit_col,
   input  logic [3:0]  edit_val,
   input  logic        edit_clr,
   output logic        edit_done,
   output logic        edit_rej,
   input  logic        chk_req,
   input  logic [1:0]  chk_addr,
   output logic        chk_ack,
   output logic [23:0] chk_data,
   input  logic        disp_req,
   input  logic [1:0]  disp_addr,
   output logic        disp_ack,
   output logic [23:0] disp_data,
   input  logic        game_won,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WAIT = 2'd2,
      WR   = 2'd3
   } stateT;

   typedef enum logic [1:0] {
      OWN_EDIT = 2'd0,
      OWN_CHK  = 2'd1,
      OWN_DISP = 2'd2
   } ownerT;

   stateT       state;
   ownerT       owner;
   logic        favorChk;
   logic [1:0]  colReg;
   logic [3:0]  valReg;
   logic        clrReg;
   logic        weReg;

   logic        editLive;
   logic        chkLive;
   logic        dispLive;
   logic        pickChk;
   logic        pickDisp;
   logic        protectHit;
   logic        valBad;
   logic        rejectEdit;
   logic [23:0] mergedWord;

   // A requester keeps its req high through the cycle its response pulse is
   // visible, so that cycle must not count as a fresh request.
   always_comb begin
      editLive = edit_req && !edit_done && !edit_rej;
      chkLive  = chk_req  && !chk_ack;
      dispLive = disp_req && !disp_ack;
   end

   // Round-robin choice between the read ports; favorChk says whose turn it
   // is when both are asking, otherwise whoever is asking gets the slot.
   always_comb begin
      pickChk  = chkLive && (favorChk || !dispLive);
      pickDisp = dispLive && !pickChk;
   end

   // Edit legality and the read-modify-write merge, evaluated against the
   // row data arriving in WAIT. Bit positions are built by concatenation:
   // protect bit 20+c is {101,c}, blank bit 16+c is {100,c}, digit base 4c
   // is {0,c,00}.
   always_comb begin
      protectHit = RamDat[{3'b101, colReg}];
      valBad     = !clrReg && ((valReg == 4'd0) || (valReg > 4'd4));
      rejectEdit = protectHit || game_won || valBad;

      mergedWord = RamDat;
      mergedWord[{1'b0, colReg, 2'b00} +: 4] = clrReg ? 4'd0 : valReg;
      mergedWord[{3'b100, colReg}]           = clrReg;
   end

   // Main FSM. Response pulses and the write strobe default low every cycle
   // so each one lasts exactly one cycle. RamAddr is loaded at grant time so
   // the row is already on the bus during RD, and it stays put through WAIT
   // and WR. Edit grants leave the round-robin pointer alone.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= IDLE;
         owner     <= OWN_EDIT;
         favorChk  <= 1'b1;
         colReg    <= 2'd0;
         valReg    <= 4'd0;
         clrReg    <= 1'b0;
         weReg     <= 1'b0;
         RamAddr   <= 2'd0;
         RamWrDat  <= 24'd0;
         edit_done <= 1'b0;
         edit_rej  <= 1'b0;
         chk_ack   <= 1'b0;
         chk_data  <= 24'd0;
         disp_ack  <= 1'b0;
         disp_data <= 24'd0;
      end else begin
         edit_done <= 1'b0;
         edit_rej  <= 1'b0;
         chk_ack   <= 1'b0;
         disp_ack  <= 1'b0;
         weReg     <= 1'b0;

         unique case (state)
            IDLE: begin
               if (editLive) begin
                  owner   <= OWN_EDIT;
                  RamAddr <= edit_row;
                  colReg  <= edit_col;
                  valReg  <= edit_val;
                  clrReg  <= edit_clr;
                  state   <= RD;
               end else if (pickChk) begin
                  owner    <= OWN_CHK;
                  RamAddr  <= chk_addr;
                  favorChk <= 1'b0;
                  state    <= RD;
               end else if (pickDisp) begin
                  owner    <= OWN_DISP;
                  RamAddr  <= disp_addr;
                  favorChk <= 1'b1;
                  state    <= RD;
               end
            end

            RD: begin
               state <= WAIT;
            end

            WAIT: begin
               unique case (owner)
                  OWN_CHK: begin
                     chk_data <= RamDat;
                     chk_ack  <= 1'b1;
                     state    <= IDLE;
                  end
                  OWN_DISP: begin
                     disp_data <= RamDat;
                     disp_ack  <= 1'b1;
                     state     <= IDLE;
                  end
                  default: begin
                     if (rejectEdit) begin
                        edit_rej <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        RamWrDat <= mergedWord;
                        weReg    <= 1'b1;
                        state    <= WR;
                     end
                  end
               endcase
            end

            WR: begin
               edit_done <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   // The strobe is qualified with RST_N so a reset landing in WR kills the
   // write in that very cycle instead of one cycle later.
   assign RamWe = weReg && RST_N;
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_game_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_game_ram_arbiter
//
// Bench for game_ram_arbiter. Holds a four-row RAM model with registered
// read data, drives the three requesters from tasks, and keeps scoreboard
// queues of expected read data, write words and edit outcomes that a
// negedge monitor pops as the DUT responds.
// ---------------------------------------------------------------------------
module tb_game_ram_arbiter;

   logic        CLK;
   logic        RST_N;
   logic [1:0]  RamAddr;
   logic [23:0] RamDat;
   logic [23:0] RamWrDat;
   logic        RamWe;
   logic        edit_req;
   logic [1:0]  edit_row;
   logic [1:0]  edit_col;
   logic [3:0]  edit_val;
   logic        edit_clr;
   logic        edit_done;
   logic        edit_rej;
   logic        chk_req;
   logic [1:0]  chk_addr;
   logic        chk_ack;
   logic [23:0] chk_data;
   logic        disp_req;
   logic [1:0]  disp_addr;
   logic        disp_ack;
   logic [23:0] disp_data;
   logic        game_won;
   logic        busy;

   int errors;
   int checks;
   int weCount;
   int doneCount;

   logic [23:0] mem [4];
   logic        ldEn;
   logic [1:0]  ldAddr;
   logic [23:0] ldData;

   logic [23:0] chkQ[$];
   logic [23:0] dispQ[$];
   logic [23:0] wrQ[$];
   logic        editQ[$];
   byte         orderLog[$];

   game_ram_arbiter dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .RamAddr   (RamAddr),
      .RamDat    (RamDat),
      .RamWrDat  (RamWrDat),
      .RamWe     (RamWe),
      .edit_req  (edit_req),
      .edit_row  (edit_row),
      .edit_col  (edit_col),
      .edit_val  (edit_val),
      .edit_clr  (edit_clr),
      .edit_done (edit_done),
      .edit_rej  (edit_rej),
      .chk_req   (chk_req),
      .chk_addr  (chk_addr),
      .chk_ack   (chk_ack),
      .chk_data  (chk_data),
      .disp_req  (disp_req),
      .disp_addr (disp_addr),
      .disp_ack  (disp_ack),
      .disp_data (disp_data),
      .game_won  (game_won),
      .busy      (busy)
   );

   // Free-running clock, 10 time units per cycle.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // RAM model: registered read, write on RamWe, plus a bench load port.
   always @(posedge CLK) begin
      if (ldEn) mem[ldAddr] <= ldData;
      else if (RamWe) mem[RamAddr] <= RamWrDat;
      RamDat <= mem[RamAddr];
   end

   // Scoreboard monitor: every response pulse or write strobe must match the
   // oldest expectation queued for it, and no two pulses may share a cycle.
   always @(negedge CLK) begin
      if (RST_N) begin
         if ((32'(chk_ack) + 32'(disp_ack) + 32'(edit_done) + 32'(edit_rej)) > 1) begin
            errors++;
            $display("[TB] FAIL onePulse: ack=%b dack=%b done=%b rej=%b, required at most one high",
                     chk_ack, disp_ack, edit_done, edit_rej);
         end
         if (chk_ack) begin
            checks++;
            orderLog.push_back("C");
            if (chkQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL chkAckUnexpected: chk_data=%h, required no ack", chk_data);
            end else begin
               logic [23:0] exp;
               exp = chkQ.pop_front();
               if (chk_data !== exp) begin
                  errors++;
                  $display("[TB] FAIL chkData: got %h, required %h", chk_data, exp);
               end
            end
         end
         if (disp_ack) begin
            checks++;
            orderLog.push_back("D");
            if (dispQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL dispAckUnexpected: disp_data=%h, required no ack", disp_data);
            end else begin
               logic [23:0] exp;
               exp = dispQ.pop_front();
               if (disp_data !== exp) begin
                  errors++;
                  $display("[TB] FAIL dispData: got %h, required %h", disp_data, exp);
               end
            end
         end
         if (RamWe) begin
            checks++;
            weCount++;
            if (wrQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL weUnexpected: RamWrDat=%h, required no write", RamWrDat);
            end else begin
               logic [23:0] exp;
               exp = wrQ.pop_front();
               if (RamWrDat !== exp) begin
                  errors++;
                  $display("[TB] FAIL ramWrDat: got %h, required %h", RamWrDat, exp);
               end
            end
         end
         if (edit_done || edit_rej) begin
            checks++;
            if (edit_done) doneCount++;
            orderLog.push_back("E");
            if (editQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL editUnexpected: done=%b rej=%b, required none", edit_done, edit_rej);
            end else begin
               logic expAcc;
               expAcc = editQ.pop_front();
               if (edit_done !== expAcc) begin
                  errors++;
                  $display("[TB] FAIL editOutcome: done=%b rej=%b, required done=%b", edit_done, edit_rej, expAcc);
               end
            end
         end
      end
   end

   // Independent model of the digit merge using masks and shifts.
   function automatic logic [23:0] modelMerge(input logic [23:0] w, input int c,
                                              input logic [3:0] v, input logic clr);
      logic [23:0] r;
      logic [3:0]  d;
      d = clr ? 4'd0 : v;
      r = w & ~(24'hF << (4 * c)) & ~(24'h1 << (16 + c));
      r = r | ({20'd0, d} << (4 * c)) | ({23'd0, clr} << (16 + c));
      return r;
   endfunction

   task automatic loadRow(input logic [1:0] a, input logic [23:0] d);
      @(posedge CLK); #1;
      ldAddr = a;
      ldData = d;
      ldEn   = 1'b1;
      @(posedge CLK); #1;
      ldEn   = 1'b0;
   endtask

   task automatic chkRead(input logic [1:0] a, input logic [23:0] expData, input int expLat);
      int  n;
      bit  seen;
      @(posedge CLK); #1;
      chkQ.push_back(expData);
      chk_addr = a;
      chk_req  = 1'b1;
      n = 0;
      seen = 0;
      while (!seen && n < 40) begin
         @(negedge CLK);
         if (chk_ack) seen = 1;
         else n++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL chkTimeout: no ack in %0d cycles, required ack", n);
      end else if (expLat >= 0) begin
         checks++;
         if (n !== expLat) begin
            errors++;
            $display("[TB] FAIL chkLatency: got %0d, required %0d", n, expLat);
         end
      end
      @(posedge CLK); #1;
      chk_req = 1'b0;
   endtask

   task automatic dispRead(input logic [1:0] a, input logic [23:0] expData, input int expLat);
      int  n;
      bit  seen;
      @(posedge CLK); #1;
      dispQ.push_back(expData);
      disp_addr = a;
      disp_req  = 1'b1;
      n = 0;
      seen = 0;
      while (!seen && n < 40) begin
         @(negedge CLK);
         if (disp_ack) seen = 1;
         else n++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL dispTimeout: no ack in %0d cycles, required ack", n);
      end else if (expLat >= 0) begin
         checks++;
         if (n !== expLat) begin
            errors++;
            $display("[TB] FAIL dispLatency: got %0d, required %0d", n, expLat);
         end
      end
      @(posedge CLK); #1;
      disp_req = 1'b0;
   endtask

   task automatic doEdit(input logic [1:0] row, input logic [1:0] col, input logic [3:0] val,
                         input logic clr, input logic expAcc, input logic [23:0] expWord,
                         input int expLat);
      int  n;
      bit  seen;
      @(posedge CLK); #1;
      if (expAcc) wrQ.push_back(expWord);
      editQ.push_back(expAcc);
      edit_row = row;
      edit_col = col;
      edit_val = val;
      edit_clr = clr;
      edit_req = 1'b1;
      n = 0;
      seen = 0;
      while (!seen && n < 40) begin
         @(negedge CLK);
         if (edit_done || edit_rej) seen = 1;
         else n++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL editTimeout: no response in %0d cycles, required response", n);
      end else if (expLat >= 0) begin
         checks++;
         if (n !== expLat) begin
            errors++;
            $display("[TB] FAIL editLatency: got %0d, required %0d", n, expLat);
         end
      end
      @(posedge CLK); #1;
      edit_req = 1'b0;
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstBusy: got %b, required 0", busy); end
      checks++;
      if (RamAddr !== 2'd0) begin errors++; $display("[TB] FAIL rstRamAddr: got %h, required 0", RamAddr); end
      checks++;
      if (RamWrDat !== 24'd0 || RamWe !== 1'b0) begin
         errors++; $display("[TB] FAIL rstWrite: RamWrDat=%h RamWe=%b, required 0/0", RamWrDat, RamWe);
      end
      checks++;
      if ({chk_ack, disp_ack, edit_done, edit_rej} !== 4'b0) begin
         errors++; $display("[TB] FAIL rstPulses: got %b, required 0000", {chk_ack, disp_ack, edit_done, edit_rej});
      end
      checks++;
      if (chk_data !== 24'd0 || disp_data !== 24'd0) begin
         errors++; $display("[TB] FAIL rstData: chk=%h disp=%h, required 0/0", chk_data, disp_data);
      end
      @(posedge CLK); #1;
      RST_N = 1'b1;
   endtask

   task automatic test_chk_read;
      int we0;
      loadRow(2'd2, 24'h0F1234);
      we0 = weCount;
      chkRead(2'd2, 24'h0F1234, 3);
      checks++;
      if (weCount !== we0) begin errors++; $display("[TB] FAIL chkNoWrite: writes=%0d, required %0d", weCount, we0); end
   endtask

   task automatic test_disp_hold;
      loadRow(2'd3, 24'h00ABCD);
      dispRead(2'd3, 24'h00ABCD, 3);
      checks++;
      if (chk_data !== 24'h0F1234) begin
         errors++; $display("[TB] FAIL chkHold: got %h, required 0f1234", chk_data);
      end
   endtask

   task automatic test_edit_accept;
      int we0;
      loadRow(2'd1, 24'h0C0030);
      we0 = weCount;
      doEdit(2'd1, 2'd1, 4'd4, 1'b0, 1'b1, 24'h0C0040, 4);
      checks++;
      if (weCount !== we0 + 1) begin errors++; $display("[TB] FAIL acceptWeOnce: writes=%0d, required %0d", weCount - we0, 1); end
      checks++;
      if (mem[1] !== 24'h0C0040) begin errors++; $display("[TB] FAIL acceptRam: row1=%h, required 0c0040", mem[1]); end
   endtask

   task automatic test_edit_reject;
      int we0;
      loadRow(2'd0, 24'h1E0001);
      we0 = weCount;
      doEdit(2'd0, 2'd0, 4'd3, 1'b0, 1'b0, 24'd0, 3);
      doEdit(2'd0, 2'd1, 4'd0, 1'b0, 1'b0, 24'd0, 3);
      doEdit(2'd0, 2'd1, 4'd5, 1'b0, 1'b0, 24'd0, 3);
      game_won = 1'b1;
      doEdit(2'd0, 2'd1, 4'd2, 1'b0, 1'b0, 24'd0, 3);
      game_won = 1'b0;
      checks++;
      if (weCount !== we0) begin errors++; $display("[TB] FAIL rejectNoWrite: writes=%0d, required 0", weCount - we0); end
      checks++;
      if (mem[0] !== 24'h1E0001) begin errors++; $display("[TB] FAIL rejectRam: row0=%h, required 1e0001", mem[0]); end
   endtask

   task automatic test_clear;
      loadRow(2'd3, 24'h001234);
      doEdit(2'd3, 2'd3, 4'd0, 1'b1, 1'b1, 24'h080234, 4);
      checks++;
      if (mem[3] !== 24'h080234) begin errors++; $display("[TB] FAIL clearRam: row3=%h, required 080234", mem[3]); end
   endtask

   task automatic test_edit_sweep;
      logic [23:0] shadow;
      logic [23:0] exp;
      logic [3:0]  v;
      shadow = 24'h0F1234;
      loadRow(2'd2, shadow);
      for (int c = 0; c < 4; c++) begin
         v = 4'($urandom_range(1, 4));
         exp = modelMerge(shadow, c, v, (c == 2));
         doEdit(2'd2, 2'(c), v, (c == 2), 1'b1, exp, 4);
         shadow = exp;
      end
      checks++;
      if (mem[2] !== shadow) begin errors++; $display("[TB] FAIL sweepRam: row2=%h, required %h", mem[2], shadow); end
   endtask

   task automatic test_arbitration;
      string got;
      loadRow(2'd1, 24'h000000);
      loadRow(2'd2, 24'h0F1234);
      loadRow(2'd3, 24'h00ABCD);
      loadRow(2'd0, 24'h1E0001);
      orderLog.delete();
      fork
         doEdit(2'd1, 2'd2, 4'd1, 1'b0, 1'b1, 24'h000100, 4);
         begin
            chkRead(2'd2, 24'h0F1234, -1);
            chkRead(2'd0, 24'h1E0001, -1);
         end
         dispRead(2'd3, 24'h00ABCD, -1);
      join
      got = "";
      foreach (orderLog[i]) got = {got, string'(orderLog[i])};
      checks++;
      if (got != "ECDC") begin errors++; $display("[TB] FAIL grantOrder: got %s, required ECDC", got); end
   endtask

   task automatic test_reset_mid_edit;
      int we0;
      int done0;
      loadRow(2'd3, 24'h000000);
      we0   = weCount;
      done0 = doneCount;
      // Reset lands in WAIT (cycle 2 after the request).
      @(posedge CLK); #1;
      edit_row = 2'd3; edit_col = 2'd0; edit_val = 4'd2; edit_clr = 1'b0; edit_req = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b0;
      edit_req = 1'b0;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(negedge CLK);
      checks++;
      if (busy !== 1'b0 || RamAddr !== 2'd0 || RamWrDat !== 24'd0 || chk_data !== 24'd0) begin
         errors++;
         $display("[TB] FAIL midWaitReset: busy=%b addr=%h wr=%h chk=%h, required 0/0/0/0", busy, RamAddr, RamWrDat, chk_data);
      end
      repeat (6) @(negedge CLK);
      checks++;
      if (weCount !== we0 || doneCount !== done0) begin
         errors++; $display("[TB] FAIL midWaitNoWrite: writes=%0d dones=%0d, required 0/0", weCount - we0, doneCount - done0);
      end
      // Reset lands in WR (cycle 3 after the request).
      @(posedge CLK); #1;
      edit_row = 2'd3; edit_col = 2'd1; edit_val = 4'd3; edit_clr = 1'b0; edit_req = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RST_N = 1'b0;
      edit_req = 1'b0;
      @(negedge CLK);
      checks++;
      if (RamWe !== 1'b0) begin errors++; $display("[TB] FAIL midWrWe: got %b, required 0", RamWe); end
      @(posedge CLK); #1;
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);
      checks++;
      if (mem[3] !== 24'h000000 || doneCount !== done0) begin
         errors++; $display("[TB] FAIL midWrRam: row3=%h dones=%0d, required 000000/0", mem[3], doneCount - done0);
      end
      loadRow(2'd1, 24'h0A5A5A);
      chkRead(2'd1, 24'h0A5A5A, 3);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      weCount   = 0;
      doneCount = 0;
      RST_N     = 1'b0;
      ldEn = 1'b0; ldAddr = 2'd0; ldData = 24'd0;
      edit_req = 1'b0; edit_row = 2'd0; edit_col = 2'd0; edit_val = 4'd0; edit_clr = 1'b0;
      chk_req = 1'b0; chk_addr = 2'd0; disp_req = 1'b0; disp_addr = 2'd0;
      game_won = 1'b0;
      test_reset();
      test_chk_read();
      test_disp_hold();
      test_edit_accept();
      test_edit_reject();
      test_clear();
      test_edit_sweep();
      test_arbitration();
      test_reset_mid_edit();
      repeat (3) @(negedge CLK);
      checks++;
      if (chkQ.size() + dispQ.size() + wrQ.size() + editQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL pendingScoreboard: left %0d, required 0", chkQ.size() + dispQ.size() + wrQ.size() + editQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_ram_arbiter.md
GAME_RAM_ARBITER -- requirements
Module: game_ram_arbiter

Interface
REQ-001 SHALL have ports: CLK in 1, system clock; all logic on posedge CLK.
REQ-002 SHALL have RST_N in 1, reset; one clock, reset is synchronous and active-low.
REQ-003 SHALL have RamAddr out 2, game row address to the single-port game RAM.
REQ-004 SHALL have RamDat in 24, RAM read data, valid the cycle after RamAddr is presented.
- Word layout: [23:20] write-protect per digit; [19:16] blank per digit; [15:0] four 4-bit digits.
- Digit c occupies [4c+3:4c], blank bit 16+c, protect bit 20+c.
REQ-005 SHALL have RamWrDat out 24 and RamWe out 1, the write word and a one-cycle write strobe.
REQ-006 SHALL have edit_req in 1, edit_row in 2, edit_col in 2, edit_val in 4 and edit_clr in 1: the user-edit request.
REQ-007 SHALL have edit_done out 1 and edit_rej out 1, one-cycle completion and rejection pulses.
REQ-008 SHALL have chk_req in 1, chk_addr in 2, chk_ack out 1 and chk_data out 24: the checker read port.
REQ-009 SHALL have disp_req in 1, disp_addr in 2, disp_ack out 1 and disp_data out 24: the display read port.
REQ-010 SHALL have game_won in 1; while high, all edits are rejected.
REQ-011 SHALL have busy out 1, high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RD, WAIT, WR.
REQ-013 In IDLE, SHALL grant one requester and latch its fields, then go to RD.
- Priority: edit first, then round-robin between chk and disp.
- No request: remain in IDLE.
REQ-014 Round-robin pointer SHALL favor chk after reset and SHALL point to the other read port after each read grant.
- Edit grants do not move the pointer.
REQ-015 In RD, SHALL drive RamAddr with the latched row, then go to WAIT.
- RamAddr holds the latched row through WAIT and WR.
REQ-016 In WAIT for a read grant, SHALL register RamDat into that port's data register, pulse its ack next cycle, and return to IDLE.
- Request-to-ack latency is 3 cycles.
REQ-017 In WAIT for an edit, SHALL reject if any of: protect bit of edit_col is set; game_won is 1; edit_clr=0 and edit_val not in 1..4.
- Rejection: edit_rej pulses next cycle, no RAM write, return to IDLE.
REQ-018 For an accepted edit, SHALL register the merged word and go to WR.
- edit_clr=1: digit 0, blank bit 1.
- Otherwise: digit edit_val, blank bit 0.
- Protect bits and other digits unchanged.
REQ-019 In WR, SHALL assert RamWe for exactly one cycle with RamWrDat equal to the merged word, pulse edit_done next cycle, and return to IDLE.
- Edit latency is 4 cycles from request to edit_done.
REQ-020 Requesters SHALL hold req and fields stable until their ack, done or rej.
- In the cycle a requester's ack, done or rej is high, the arbiter SHALL NOT grant that requester again.
REQ-021 chk_data and disp_data SHALL hold their last value until the next ack on that port.
REQ-022 SHALL assert at most one ack, done or rej per cycle, and RamWe only in WR.

Reset
REQ-023 With RST_N=0 at a clock edge, SHALL go to IDLE and abandon any transaction in progress without write or ack.
- Reset values: RamAddr 0, RamWrDat 0, RamWe 0, all ack/done/rej 0, chk_data and disp_data 0, busy 0, pointer favoring chk.
REQ-024 Reset mid-WR SHALL suppress RamWe in the cycle RST_N is sampled low.

Verification
REQ-025 Checker read: chk_req, chk_addr=2, RAM row2=0x0F1234 -> chk_ack and chk_data=0x0F1234 three cycles after request; no RamWe.
REQ-026 Edit accept: row1=0x0C0030, edit col 1, val 4, clr 0 -> RamWe once, RamWrDat=0x0C0040, edit_done at cycle 4.
REQ-027 Edit reject: row0=0x1E0001, edit col 0, val 3 -> edit_rej, no RamWe. Same request with val 0, or with game_won=1 on an unprotected col -> edit_rej.
REQ-028 Arbitration: edit, chk and disp requested together -> edit served first, then chk, then disp; with chk and disp held, grants alternate chk, disp, chk.
REQ-029 Clear: edit_clr=1, col 3 on row3=0x001234 -> RamWrDat=0x080234.
REQ-030 Reset during WAIT of an edit -> no RamWe, no edit_done; outputs at reset values; the next request is serviced normally.
